// File: rtl/var_data_delay.sv
// Multi-lane programmable video delay line over a circular buffer; all lanes share one delay.
// Define DATA_DELAY_CE_EN to add the I_en advance enable; otherwise every clock edge advances.
module var_data_delay #(
    parameter int DATA_WIDTH = 8,
    parameter int CH_NUM     = 3,
    parameter int MAX_DELAY  = 16,
    parameter int DLY_W      = 5
) (
    input  logic                         I_video_clk,
    input  logic                         I_rst_n,
`ifdef DATA_DELAY_CE_EN
    input  logic                         I_en,
`endif
    input  logic [DLY_W-1:0]             I_delay,
    input  logic [CH_NUM*DATA_WIDTH-1:0] I_data,
    output logic [CH_NUM*DATA_WIDTH-1:0] O_data,
    output logic                         O_valid
);

    localparam int BUS_W = CH_NUM * DATA_WIDTH;
    localparam int PTR_W = $clog2(MAX_DELAY);
    localparam int SUM_W = DLY_W + 2;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_DELAY - 1);
    localparam logic [DLY_W-1:0] DLY_MAX  = DLY_W'(MAX_DELAY);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    logic             w_en;
    logic [DLY_W-1:0] w_de;
    logic             w_chg;

`ifdef DATA_DELAY_CE_EN
    assign w_en = I_en;
`else
    assign w_en = 1'b1;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DLY_W-1:0]   r_dly_q;
    logic [DLY_W-1:0]   r_fill_cnt;
    logic [DLY_W-1:0]   w_fill_nxt;
    logic [DLY_W:0]     w_fill_inc;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [BUS_W-1:0]   r_mem [MAX_DELAY];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   w_rd_ptr;
    logic [SUM_W-1:0]   w_rd_sum;
    logic [BUS_W-1:0]   w_sample;
    logic [BUS_W-1:0]   r_data;

    always_comb begin
        if (I_delay == '0) begin
            w_de = DLY_ONE;
        end else if (I_delay > DLY_MAX) begin
            w_de = DLY_MAX;
        end else begin
            w_de = I_delay;
        end
    end

    assign w_chg      = (w_de != r_dly_q);
    assign w_fill_inc = {1'b0, r_fill_cnt} + {{DLY_W{1'b0}}, 1'b1};

    // Oldest slot still needed: (wr_ptr - De + 1) mod MAX_DELAY, kept non-negative by adding MAX_DELAY.
    assign w_rd_sum = SUM_W'(r_wr_ptr) + SUM_W'(MAX_DELAY + 1) - SUM_W'(r_dly_q);
    assign w_rd_ptr = (w_rd_sum >= SUM_W'(MAX_DELAY)) ? PTR_W'(w_rd_sum - SUM_W'(MAX_DELAY))
                                                      : PTR_W'(w_rd_sum);

    // De=1 reads the slot being written this edge, so bypass the buffer.
    assign w_sample = (r_dly_q == DLY_ONE) ? I_data : r_mem[w_rd_ptr];

    always_ff @(posedge I_video_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state    <= S_FILL;
            r_fill_cnt <= '0;
            r_valid    <= 1'b0;
            r_dly_q    <= DLY_ONE;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_nxt;
            r_valid    <= w_valid_nxt;
            r_dly_q    <= w_de;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill_cnt;
        w_valid_nxt = r_valid;
        if (w_chg) begin
            w_state_nxt = S_FILL;
            w_fill_nxt  = w_en ? DLY_ONE : '0;
            w_valid_nxt = 1'b0;
        end else if (w_en) begin
            case (r_state)
                S_FILL: begin
                    w_fill_nxt = w_fill_inc[DLY_W-1:0];
                    // >= covers a change to De=1, where the change edge alone already filled the pipe
                    if (w_fill_inc >= {1'b0, w_de}) begin
                        w_state_nxt = S_RUN;
                        w_valid_nxt = 1'b1;
                    end
                end
                S_RUN: begin
                    w_valid_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = S_FILL;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge I_video_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_wr_ptr <= '0;
            r_data   <= '0;
            for (int i = 0; i < MAX_DELAY; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_en) begin
                r_mem[r_wr_ptr] <= I_data;
                r_wr_ptr        <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_en || w_chg) begin
                r_data <= w_valid_nxt ? w_sample : '0;
            end
        end
    end

    assign O_data  = r_data;
    assign O_valid = r_valid;

endmodule

// File: tb/tb_var_data_delay.sv
// Scoreboard bench for var_data_delay: a history-array reference model predicts every edge,
// a negedge monitor pops and compares.
module tb_var_data_delay;

    localparam int DW   = 8;
    localparam int CH   = 3;
    localparam int MAXD = 16;
    localparam int DLYW = 5;
    localparam int BW   = DW * CH;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [DLYW-1:0] dly;
    logic [BW-1:0]   din;
    logic [BW-1:0]   dout;
    logic            vout;

    always #5 clk = ~clk;

    var_data_delay #(
        .DATA_WIDTH(DW),
        .CH_NUM    (CH),
        .MAX_DELAY (MAXD),
        .DLY_W     (DLYW)
    ) dut (
        .I_video_clk(clk),
        .I_rst_n    (rst_n),
`ifdef DATA_DELAY_CE_EN
        .I_en       (en),
`endif
        .I_delay    (dly),
        .I_data     (din),
        .O_data     (dout),
        .O_valid    (vout)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [BW:0]   exp_q [$];
    logic [BW-1:0] hist [0:4095];
    int            k;
    int            m_dly;
    int            m_cnt;
    bit            m_valid;
    logic [BW-1:0] m_data;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at time %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [BW-1:0] lanes(input int l0, input int l1, input int l2);
        logic [DW-1:0] a, b, c;
        a = DW'(l0);
        b = DW'(l1);
        c = DW'(l2);
        return {c, b, a};
    endfunction

    task automatic model_reset();
        k       = 0;
        m_dly   = 1;
        m_cnt   = 0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    // Reference: O_data after enabled edge n is the sample of enabled edge n-De+1, once
    // at least De enabled edges have passed since reset or the last delay change.
    task automatic step(input bit e, input int d, input logic [BW-1:0] x);
        bit ee;
        int de;
        bit chg;
        int kidx;
`ifdef DATA_DELAY_CE_EN
        ee = e;
`else
        ee = 1'b1;
`endif
        en  = ee;
        dly = DLYW'(d);
        din = x;
        @(posedge clk);
        de   = (d == 0) ? 1 : ((d > MAXD) ? MAXD : d);
        chg  = (de != m_dly);
        kidx = k;
        if (ee) begin
            hist[k % 4096] = x;
            k++;
        end
        if (chg) begin
            m_dly   = de;
            m_cnt   = ee ? 1 : 0;
            m_valid = 1'b0;
        end else if (ee) begin
            m_cnt++;
            if (m_cnt >= de) m_valid = 1'b1;
        end
        if (chg || ee) m_data = m_valid ? hist[(kidx - de + 1) % 4096] : '0;
        exp_q.push_back({m_valid, m_data});
        #1;
    endtask

    // Asserted between edges; outputs must clear with no clock edge.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_valid", BW'(vout), '0);
        check("rst_data", dout, '0);
        repeat (2) @(posedge clk);
        #2;
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        logic [BW:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("valid", BW'(vout), BW'(e[BW]));
                check("data", dout, e[BW-1:0]);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int cur_d;
        rst_n = 1'b0;
        en    = 1'b0;
        dly   = '0;
        din   = '0;
        model_reset();
        #3;
        do_reset();

        // Fill from reset with De=5, lane0 ramp
        for (int n = 0; n < 14; n++) step(1'b1, 5, lanes(n, 0, 0));

        // Clamp low: De=1 from reset
        do_reset();
        for (int n = 0; n < 6; n++) step(1'b1, 0, lanes(n + 40, n, 7));

        // Clamp high: 31 -> MAX_DELAY
        do_reset();
        for (int n = 0; n < 40; n++) step(1'b1, 31, lanes(n, 3 * n, 200 - n));

        // Delay change 5 -> 8 at edge 20
        do_reset();
        for (int n = 1; n <= 34; n++) step(1'b1, (n < 20) ? 5 : 8, lanes(n, n + 1, n + 2));

        // Alternating enable, De=3
        do_reset();
        for (int n = 1; n <= 16; n++) step(n % 2 == 1, 3, lanes(10 * n, n, 255 - n));

        // Pointer wrap with De=16
        do_reset();
        for (int n = 0; n < 100; n++) step(1'b1, 16, lanes(n, 255 - n, n ^ 8'hA5));

        // Async reset in mid-run with De=8, then refill
        do_reset();
        for (int n = 0; n < 40; n++) step(1'b1, 8, lanes(n + 1, n * 5, n ^ 8'h3C));
        do_reset();
        for (int n = 0; n < 12; n++) step(1'b1, 8, lanes(n + 100, n, 1));

        // Delay changing every cycle, including decreases to 1
        for (int n = 0; n < 12; n++) step(1'b1, (n % 3 == 0) ? 1 : $urandom_range(0, 31), BW'($urandom));
        for (int n = 0; n < 6; n++) step(1'b1, 1, BW'($urandom));

        // Random enable, occasional random delay changes
        cur_d = 4;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) cur_d = $urandom_range(0, 31);
            step($urandom_range(0, 9) < 7, cur_d, BW'($urandom));
        end

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        #1;
        check("drain", BW'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
